// File: rtl/cdf_histogram_fetch.sv
// Head of the CDF pipeline: streams histogram bins from a synchronous read port and
// presents them, with their CDF store addresses, to the accumulate stage in framed runs.
module cdf_histogram_fetch #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  Go,
    input  logic                  Abort,
    input  logic [ADDR_WIDTH-1:0] HistBase,
    input  logic [ADDR_WIDTH-1:0] CdfBase,
    input  logic [ADDR_WIDTH-1:0] BinCount,
    output logic                  MemReadEn,
    output logic [ADDR_WIDTH-1:0] MemReadAddr,
    input  logic [DATA_WIDTH-1:0] MemReadData,
    output logic [DATA_WIDTH-1:0] AccumlateOut,
    output logic                  StartOut,
    output logic [ADDR_WIDTH-1:0] StoreAddressOut,
    output logic                  Busy,
    output logic                  Done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_hist_base;
    logic [ADDR_WIDTH-1:0]   r_cdf_base;
    logic [ADDR_WIDTH-1:0]   r_count;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [ADDR_WIDTH-1:0]   r_idx_p0;
    logic                    r_vld_p0;
    logic                    r_start;
    logic [DATA_WIDTH-1:0]   r_accum;
    logic [ADDR_WIDTH-1:0]   r_store;
    logic                    r_done;
    logic                    w_accept;
    logic                    w_abort;
    logic                    w_last_issue;
    logic                    w_done_nxt;
    logic                    w_emit;

    assign w_accept     = (r_state == IDLE) && Go && !Abort;
    assign w_abort      = (r_state != IDLE) && Abort;
    assign w_last_issue = (r_idx == (r_count - ADDR_WIDTH'(1)));
    // Read data is only consumed the cycle after its strobe; an abort discards it.
    assign w_emit       = r_vld_p0 && !w_abort;

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (BinCount != '0) w_state_nxt = READ;
                    else                w_done_nxt  = 1'b1;
                end
            end
            READ: begin
                if (Abort)             w_state_nxt = IDLE;
                else if (w_last_issue) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (Abort) begin
                    w_state_nxt = IDLE;
                end else if (!r_vld_p0) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_hist_base <= '0;
            r_cdf_base  <= '0;
            r_count     <= '0;
            r_idx       <= '0;
            r_idx_p0    <= '0;
            r_vld_p0    <= 1'b0;
            r_start     <= 1'b0;
            r_accum     <= '0;
            r_store     <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (w_accept) begin
                r_hist_base <= HistBase;
                r_cdf_base  <= CdfBase;
                r_count     <= BinCount;
                r_idx       <= '0;
            end else if (r_state == READ) begin
                r_idx <= r_idx + ADDR_WIDTH'(1);
            end
            r_vld_p0 <= (r_state == READ) && !Abort;
            r_idx_p0 <= r_idx;
            r_start  <= w_emit;
            r_accum  <= w_emit ? MemReadData : '0;
            r_store  <= w_emit ? (r_cdf_base + r_idx_p0) : '0;
        end
    end

    assign MemReadEn       = (r_state == READ);
    assign MemReadAddr     = MemReadEn ? (r_hist_base + r_idx) : '0;
    assign AccumlateOut    = r_accum;
    assign StartOut        = r_start;
    assign StoreAddressOut = r_store;
    assign Busy            = (r_state != IDLE);
    assign Done            = r_done;

endmodule

// File: doc/cdf_histogram_fetch.md
# cdf_histogram_fetch

- Head of the CDF pipeline: reads histogram bins sequentially from a synchronous read-only memory port.
- Drives the accumulate stage's value, start and store-address inputs so that the accumulate stage emits one CDF entry per bin.
- Enforces the accumulator's run framing: start is held high for exactly the bin count, with at least one low cycle between runs.

## Interface
Parameters:
- DATA_WIDTH, 16, width of histogram bins and the value output
- ADDR_WIDTH, 16, width of all addresses and of the bin count

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- Go  in  1  single-cycle run request; accepted only when Busy is low
- Abort  in  1  synchronous cancel of the current run
- HistBase  in  ADDR_WIDTH  address of bin 0 in histogram memory; sampled with an accepted Go
- CdfBase  in  ADDR_WIDTH  store address of CDF entry 0; sampled with an accepted Go
- BinCount  in  ADDR_WIDTH  number of bins to stream; sampled with an accepted Go
- MemReadEn  out  1  histogram memory read strobe
- MemReadAddr  out  ADDR_WIDTH  histogram memory read address
- MemReadData  in  DATA_WIDTH  read data, valid exactly 1 cycle after MemReadEn
- AccumlateOut  out  DATA_WIDTH  bin value to the accumulate stage
- StartOut  out  1  run-active flag to the accumulate stage
- StoreAddressOut  out  ADDR_WIDTH  CDF store address paired with AccumlateOut
- Busy  out  1  run in progress
- Done  out  1  single-cycle completion pulse

## Operation
- States are IDLE, READ and DRAIN.
- IDLE:
  - Go with BinCount != 0: latch the three bases/count, go to READ, Busy=1.
  - Go with BinCount == 0: pulse Done next cycle; no reads, no StartOut.
- READ:
  - Each cycle: MemReadEn=1, MemReadAddr = HistBase + i, where i is the issue counter (0..BinCount-1).
  - After issuing i = BinCount-1, go to DRAIN.
- Pipeline:
  - A 2-stage valid/index shift tracks in-flight reads.
  - The cycle after data returns, register AccumlateOut = MemReadData, StoreAddressOut = CdfBase + i, StartOut = 1.
- DRAIN:
  - MemReadEn=0. When the last valid leaves the pipeline, go to IDLE.
  - Done=1 for one cycle and Busy=0, in the first cycle StartOut is low.
- Address arithmetic is modulo 2^ADDR_WIDTH: HistBase+i and CdfBase+i wrap silently.
- When StartOut=0: AccumlateOut=0 and StoreAddressOut=0.
- Go while Busy=1 is ignored. Go in the Done cycle is accepted; Busy=0 in that cycle.
- Abort while Busy=1:
  - Next cycle: state IDLE, MemReadEn=0, StartOut=0, in-flight reads discarded, Busy=0.
  - No Done is pulsed.
  - Abort in IDLE has no effect. Abort and Go in the same cycle while IDLE: Abort wins, Go is ignored.
- reset: all outputs 0, state IDLE, counters and valids cleared. Reset mid-run behaves as Abort, with registers zeroed.

## Timing
- Go accepted at edge E0. MemReadEn is high from the cycle after E0 for exactly BinCount consecutive cycles.
- StartOut first rises 2 cycles after the first MemReadEn cycle. It stays high exactly BinCount consecutive cycles with no gaps.
- Each StoreAddressOut/AccumlateOut pair appears 2 cycles after its read address.
- Done follows the last StartOut cycle by 1 cycle. Total Go-to-Done time is BinCount + 3 cycles.
- Back-to-back runs always have at least 3 StartOut-low cycles between them, so the accumulator clears.
- The block never stalls, and MemReadData is never sampled except exactly 1 cycle after MemReadEn.

## Test plan
- Reset: hold reset 2 cycles, with Go=1 during reset -> all outputs 0, no MemReadEn.
- Basic run: HistBase=0x0100, CdfBase=0x0800, BinCount=4, memory holds 5,0,7,1.
  - MemReadAddr 0x100..0x103 in consecutive cycles.
  - StartOut high 4 cycles with (AccumlateOut, StoreAddressOut) = (5,0x800), (0,0x801), (7,0x802), (1,0x803).
  - Done at Go+7. Downstream accumulate outputs 5, 5, 12, 13.
- Zero count: BinCount=0 -> Done the next cycle, MemReadEn and StartOut never asserted.
- Wrap-around: HistBase=0xFFFE, CdfBase=0xFFFF, BinCount=3.
  - Read addresses 0xFFFE, 0xFFFF, 0x0000.
  - Store addresses 0xFFFF, 0x0000, 0x0001.
- Abort mid-run: BinCount=8, Abort in the 3rd READ cycle.
  - Next cycle MemReadEn=0, StartOut=0, Busy=0; no Done.
  - A new Go with BinCount=2 then runs cleanly from i=0.
- Go during Busy and back-to-back:
  - Go repeated every cycle during a BinCount=2 run -> ignored until the Done cycle.
  - Go in the Done cycle -> the second run starts, with a StartOut-low gap of 3 cycles between runs.
